// File: rtl/wave_synth.sv
// rtl/wave_synth.sv - single-note waveform synthesizer driving an unsigned DAC sample
//
// Plays one note per START request. The note's mode, step divider and duration
// are captured at acceptance and held until the note ends. A phase accumulator
// advances once every max(STEP_DIV,1) cycles and is shaped into a square,
// triangle or sawtooth sample (or silence).
//
// Ports:
//   CLK       system clock, all logic on its rising edge
//   RESET_N   asynchronous active-low reset
//   START     request one note with the current MODE / STEP_DIV / DURATION
//   ABORT     end the current note at once (no DONE); also blocks START in idle
//   MODE      00 silence, 01 square, 10 triangle, 11 sawtooth
//   STEP_DIV  clock cycles per phase step (0 behaves as 1)
//   DURATION  note length in clock cycles (0 gives an immediate DONE)
//   BUSY      high for every cycle of a playing note
//   DONE      one-cycle pulse when a note finishes naturally
//   SOUND     registered DAC sample, 0 whenever no note plays

module wave_synth #(
   parameter int DAC_W = 8,
   parameter int DIV_W = 16,
   parameter int DUR_W = 25
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic             ABORT,
   input  logic [1:0]       MODE,
   input  logic [DIV_W-1:0] STEP_DIV,
   input  logic [DUR_W-1:0] DURATION,
   output logic             BUSY,
   output logic             DONE,
   output logic [DAC_W-1:0] SOUND
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      M_SILENT   = 2'b00,
      M_SQUARE   = 2'b01,
      M_TRIANGLE = 2'b10,
      M_SAW      = 2'b11
   } mode_e;

   state_e           state_q, state_d;
   logic [1:0]       mode_q,  mode_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [DUR_W-1:0] dur_q,   dur_d;     // busy cycles left, including the current one
   logic [DAC_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] step_q,  step_d;
   logic             done_q,  done_d;
   logic [DAC_W-1:0] sound_q, sound_d;

   logic             step_last;

   // Shape a phase value into a DAC sample for the given mode.
   function automatic logic [DAC_W-1:0] wave_sample(input logic [1:0]       mode,
                                                    input logic [DAC_W-1:0] phase);
      logic [DAC_W-1:0] ramp;
      logic [DAC_W-1:0] result;
      // Rising half doubles the low phase bits; falling half mirrors it by
      // inversion, which yields 0,2..254,255,253..1 for an 8-bit DAC.
      ramp = {phase[DAC_W-2:0], 1'b0};
      case (mode_e'(mode))
         M_SILENT:   result = '0;
         M_SQUARE:   result = {DAC_W{phase[DAC_W-1]}};
         M_TRIANGLE: result = phase[DAC_W-1] ? ~ramp : ramp;
         M_SAW:      result = phase;
         default:    result = '0;
      endcase
      return result;
   endfunction

   // Divider of 0 or 1 steps the phase every cycle; otherwise the step
   // counter runs 0..div-1 and the phase advances on the wrap.
   always_comb begin
      step_last = 1'b1;
      if (div_q > DIV_W'(1)) begin
         step_last = (step_q == div_q - DIV_W'(1));
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      div_d   = div_q;
      dur_d   = dur_q;
      phase_d = phase_q;
      step_d  = step_q;
      done_d  = 1'b0;
      sound_d = sound_q;

      case (state_q)
         S_IDLE: begin
            sound_d = '0;
            if (START && !ABORT) begin
               mode_d  = MODE;
               div_d   = STEP_DIV;
               dur_d   = DURATION;
               phase_d = '0;
               step_d  = '0;
               if (DURATION == '0) begin
                  // Zero-length note: report completion without ever playing.
                  done_d = 1'b1;
               end else begin
                  state_d = S_PLAY;
                  sound_d = wave_sample(MODE, '0);
               end
            end
         end

         S_PLAY: begin
            if (ABORT) begin
               state_d = S_IDLE;
               phase_d = '0;
               step_d  = '0;
               sound_d = '0;
            end else if (dur_q == DUR_W'(1)) begin
               state_d = S_IDLE;
               phase_d = '0;
               step_d  = '0;
               done_d  = 1'b1;
               sound_d = '0;
            end else begin
               dur_d = dur_q - DUR_W'(1);
               if (step_last) begin
                  step_d  = '0;
                  phase_d = phase_q + DAC_W'(1);
               end else begin
                  step_d  = step_q + DIV_W'(1);
               end
               sound_d = wave_sample(mode_q, phase_d);
            end
         end

         default: begin
            state_d = S_IDLE;
            sound_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         div_q   <= '0;
         dur_q   <= '0;
         phase_q <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
         sound_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         div_q   <= div_d;
         dur_q   <= dur_d;
         phase_q <= phase_d;
         step_q  <= step_d;
         done_q  <= done_d;
         sound_q <= sound_d;
      end
   end

   assign BUSY  = (state_q == S_PLAY);
   assign DONE  = done_q;
   assign SOUND = sound_q;

endmodule

// File: doc/wave_synth.md
WAVE_SYNTH -- requirements
Module: wave_synth

Interface
REQ-001 The module SHALL provide parameter DAC_W, default 8, meaning the DAC sample width and phase width in bits (minimum 2).
REQ-002 The module SHALL provide parameter DIV_W, default 16, meaning the width of the step-divider count.
REQ-003 The module SHALL provide parameter DUR_W, default 25, meaning the width of the note-duration count.
REQ-004 Port CLK, input, 1 bit: single system clock (25 MHz on board); all logic is rising-edge on CLK.
REQ-005 Port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port START, input, 1 bit: request to play one note using the current MODE, STEP_DIV and DURATION.
REQ-007 Port ABORT, input, 1 bit: terminates the current note immediately.
REQ-008 Port MODE, input, 2 bits: 00 silence, 01 square, 10 triangle, 11 sawtooth.
REQ-009 Port STEP_DIV, input, DIV_W bits: CLK cycles per phase step.
REQ-010 Port DURATION, input, DUR_W bits: note length in CLK cycles.
REQ-011 Port BUSY, output, 1 bit: high while a note plays.
REQ-012 Port DONE, output, 1 bit: one-cycle pulse on natural note completion.
REQ-013 Port SOUND, output, DAC_W bits: registered unsigned DAC sample.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and PLAY.
REQ-015 In IDLE with START=1 and ABORT=0, the block SHALL latch MODE, STEP_DIV and DURATION, clear phase and step counter, and enter PLAY on the next edge; the latched values SHALL NOT change until the note ends.
REQ-016 A START sampled at edge N SHALL give BUSY=1 from edge N+1 and SOUND=waveform(phase 0) at edge N+1.
REQ-017 START while in PLAY SHALL be ignored (no restart, no queuing).
REQ-018 The step counter SHALL count CLK cycles; phase (DAC_W bits) SHALL increment by 1 every max(STEP_DIV,1) cycles in PLAY and SHALL wrap from 2^DAC_W-1 to 0; STEP_DIV=0 SHALL behave as 1.
REQ-019 Square mode: SOUND SHALL be all-ones when phase MSB=1, else 0.
REQ-020 Sawtooth mode: SOUND SHALL equal phase.
REQ-021 Triangle mode: SOUND SHALL be {phase[DAC_W-2:0],0} when phase MSB=0, else the bitwise inverse of that value (DAC_W=8: 0,2..254,255,253..1).
REQ-022 Silence mode: SOUND SHALL be 0 while BUSY stays high for the full duration.
REQ-023 BUSY SHALL be high for exactly DURATION cycles (edges N+1..N+DURATION); at edge N+DURATION+1 the FSM SHALL be IDLE, BUSY=0, DONE=1 for one cycle, SOUND=0.
REQ-024 DURATION=0 SHALL produce no PLAY cycles: BUSY stays 0 and DONE pulses at edge N+1.
REQ-025 A START in the same cycle as DONE=1 SHALL be accepted (back-to-back notes without a gap cycle).
REQ-026 ABORT=1 in PLAY SHALL force IDLE on the next edge with BUSY=0, SOUND=0, and no DONE pulse.
REQ-027 ABORT=1 with START=1 in IDLE SHALL take priority: START is ignored.
REQ-028 Output frequency SHALL be f_CLK / (max(STEP_DIV,1) * 2^DAC_W).

Reset
REQ-029 RESET_N=0 SHALL, asynchronously and regardless of CLK, force IDLE, BUSY=0, DONE=0, SOUND=0, and phase, step counter, duration counter and latched fields to 0.
REQ-030 Reset asserted mid-note SHALL abandon the note with no DONE pulse; after RESET_N rises, the block SHALL accept START on the first subsequent edge.

Verification
REQ-031 DAC_W=8, sawtooth, STEP_DIV=2, DURATION=600 -> SOUND steps 0,0,1,1,2,2…255,255,0; BUSY high 600 cycles; DONE single pulse at cycle 601.
REQ-032 Triangle, STEP_DIV=1, DURATION=300 -> SOUND 0,2,…,254,255,253,…,1,0,2…; BUSY 300 cycles, then SOUND=0 and DONE=1.
REQ-033 Square, STEP_DIV=98, DURATION=25000 -> period 25088 cycles (996.5 Hz at 25 MHz); SOUND 0 for 12544 cycles then 255; note ends before the second low half.
REQ-034 DURATION=0 START -> BUSY never high, DONE at N+1; then START during DONE cycle with DURATION=5 -> BUSY high 5 cycles immediately following.
REQ-035 ABORT at cycle 10 of a 100-cycle note -> BUSY=0, SOUND=0 next edge, no DONE; ABORT+START together in IDLE -> no BUSY.
REQ-036 RESET_N low mid-note between clock edges -> BUSY, SOUND, DONE zero immediately; START one cycle after release -> normal note from phase 0.
